// File: rtl/glitch_sequencer_if.sv
// Serial register bus for glitch_sequencer; also supplies default command codes
// when the shared command header has not already defined them.
`ifndef SEQ_DELAY
`define SEQ_DELAY  8'h60
`endif
`ifndef SEQ_WIDTH
`define SEQ_WIDTH  8'h61
`endif
`ifndef SEQ_GAP
`define SEQ_GAP    8'h62
`endif
`ifndef SEQ_COUNT
`define SEQ_COUNT  8'h63
`endif
`ifndef SEQ_CTRL
`define SEQ_CTRL   8'h64
`endif
`ifndef SEQ_STATUS
`define SEQ_STATUS 8'h65
`endif

interface glitch_sequencer_if;
  logic [7:0]  reg_cmd;
  logic [15:0] reg_bytecount;
  logic [7:0]  reg_data_in;
  logic [7:0]  reg_data_out;
  logic        reg_read;
  logic        reg_write;

  modport master (
    output reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write,
    input  reg_data_out
  );

  modport slave (
    input  reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write,
    output reg_data_out
  );
endinterface

// File: rtl/glitch_sequencer.sv
// Armed multi-pulse trigger sequencer: delay, then N pulses of width W separated by gap G.
// Optional auto-rearm (CTRL bit1, DONE->ARMED) is enabled by GLITCH_SEQ_AUTO_REARM_EN.
module glitch_sequencer #(
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned PULSES_W = 8
) (
  input  logic                timerclk,
  input  logic                reset,
  input  logic                trigger_in,
  glitch_sequencer_if.slave   regs,
  output logic                glitch_out,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CNT_BYTES = (CNT_W + 7) / 8;
  localparam int unsigned PADW      = CNT_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_PULSE = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e              state_q;
  logic [PADW-1:0]     delay_q, width_q, gap_q;
  logic [PULSES_W-1:0] count_q;
  logic                arm_q;
  logic                sticky_q;
  logic                trig_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    wk_w_q, wk_g_q;
  logic [PULSES_W-1:0] pulses_q;
  logic                glitch_q, busy_q, done_q;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
  logic                rearm_q;
`endif

  logic                trig_edge;
  logic                ctrl_wr, arm_set, abort;
  logic [CNT_W-1:0]    delay_v, width_v, gap_v;
  logic [CNT_W-1:0]    width_m1, gap_m1;
  logic [PULSES_W-1:0] npulses;
  logic                rearm_bit;
  logic [7:0]          rd_data;

  assign trig_edge = trigger_in & ~trig_q;
  assign ctrl_wr   = regs.reg_write && (regs.reg_cmd == `SEQ_CTRL) && (regs.reg_bytecount == '0);
  assign arm_set   = ctrl_wr & regs.reg_data_in[0];
  assign abort     = ctrl_wr & ~regs.reg_data_in[0] & (state_q != S_IDLE);

  assign delay_v  = delay_q[CNT_W-1:0];
  assign width_v  = width_q[CNT_W-1:0];
  assign gap_v    = gap_q[CNT_W-1:0];
  assign width_m1 = (width_v == '0) ? '0 : width_v - CNT_W'(1);
  assign gap_m1   = (gap_v == '0) ? '0 : gap_v - CNT_W'(1);
  assign npulses  = (count_q == '0) ? PULSES_W'(1) : count_q;

`ifdef GLITCH_SEQ_AUTO_REARM_EN
  assign rearm_bit = rearm_q;
`else
  assign rearm_bit = 1'b0;
`endif

  // Configuration registers; out-of-range byte indices never match and are dropped
  always_ff @(posedge timerclk) begin
    if (reset) begin
      delay_q <= '0;
      width_q <= '0;
      gap_q   <= '0;
      count_q <= '0;
    end else if (regs.reg_write) begin
      case (regs.reg_cmd)
        `SEQ_DELAY:
          for (int unsigned i = 0; i < CNT_BYTES; i++)
            if (i == 32'(regs.reg_bytecount)) delay_q[i*8 +: 8] <= regs.reg_data_in;
        `SEQ_WIDTH:
          for (int unsigned i = 0; i < CNT_BYTES; i++)
            if (i == 32'(regs.reg_bytecount)) width_q[i*8 +: 8] <= regs.reg_data_in;
        `SEQ_GAP:
          for (int unsigned i = 0; i < CNT_BYTES; i++)
            if (i == 32'(regs.reg_bytecount)) gap_q[i*8 +: 8] <= regs.reg_data_in;
        `SEQ_COUNT:
          if (regs.reg_bytecount == '0) count_q <= PULSES_W'(regs.reg_data_in);
        default: ;
      endcase
    end
  end

  // The delay counter is loaded with D (not D-1): the extra DELAY cycle with cnt==0
  // is what places the first rising edge at t+D+1, and D=0 shares the same path.
  always_ff @(posedge timerclk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      arm_q    <= 1'b0;
      sticky_q <= 1'b0;
      trig_q   <= 1'b0;
      cnt_q    <= '0;
      wk_w_q   <= '0;
      wk_g_q   <= '0;
      pulses_q <= '0;
      glitch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
      rearm_q  <= 1'b0;
`endif
    end else begin
      trig_q <= trigger_in;
      done_q <= 1'b0;
      if (abort) begin
        state_q  <= S_IDLE;
        glitch_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE:
            if (arm_q || arm_set) state_q <= S_ARMED;
          S_ARMED:
            if (trig_edge) begin
              cnt_q    <= delay_v;
              wk_w_q   <= width_m1;
              wk_g_q   <= gap_m1;
              pulses_q <= npulses;
              busy_q   <= 1'b1;
              state_q  <= S_DELAY;
            end
          S_DELAY:
            if (cnt_q == '0) begin
              glitch_q <= 1'b1;
              cnt_q    <= wk_w_q;
              state_q  <= S_PULSE;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          S_PULSE:
            if (cnt_q == '0) begin
              glitch_q <= 1'b0;
              if (pulses_q <= PULSES_W'(1)) begin
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                sticky_q <= 1'b1;
                state_q  <= S_DONE;
              end else begin
                pulses_q <= pulses_q - PULSES_W'(1);
                cnt_q    <= wk_g_q;
                state_q  <= S_GAP;
              end
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          S_GAP:
            if (cnt_q == '0) begin
              glitch_q <= 1'b1;
              cnt_q    <= wk_w_q;
              state_q  <= S_PULSE;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          S_DONE: begin
`ifdef GLITCH_SEQ_AUTO_REARM_EN
            if (rearm_q) begin
              state_q <= S_ARMED;
            end else begin
              arm_q   <= 1'b0;
              state_q <= S_IDLE;
            end
`else
            arm_q   <= 1'b0;
            state_q <= S_IDLE;
`endif
          end
          default: state_q <= S_IDLE;
        endcase
      end
      // A CTRL write takes precedence over the automatic arm clear in DONE
      if (ctrl_wr) begin
        arm_q <= regs.reg_data_in[0];
`ifdef GLITCH_SEQ_AUTO_REARM_EN
        rearm_q <= regs.reg_data_in[1];
`endif
        if (regs.reg_data_in[0]) sticky_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (regs.reg_read) begin
      case (regs.reg_cmd)
        `SEQ_DELAY:
          for (int unsigned i = 0; i < CNT_BYTES; i++)
            if (i == 32'(regs.reg_bytecount)) rd_data = delay_q[i*8 +: 8];
        `SEQ_WIDTH:
          for (int unsigned i = 0; i < CNT_BYTES; i++)
            if (i == 32'(regs.reg_bytecount)) rd_data = width_q[i*8 +: 8];
        `SEQ_GAP:
          for (int unsigned i = 0; i < CNT_BYTES; i++)
            if (i == 32'(regs.reg_bytecount)) rd_data = gap_q[i*8 +: 8];
        `SEQ_COUNT:
          if (regs.reg_bytecount == '0) rd_data = 8'(count_q);
        `SEQ_CTRL:
          if (regs.reg_bytecount == '0) rd_data = {6'b0, rearm_bit, arm_q};
        `SEQ_STATUS:
          if (regs.reg_bytecount == '0) rd_data = {3'b0, state_q, sticky_q, busy_q};
        default: ;
      endcase
    end
  end

  assign regs.reg_data_out = rd_data;
  assign glitch_out        = glitch_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
- Programmable multi-pulse trigger sequencer for the glitch/trigger path.
- Once armed, waits for a rising edge on trigger_in, waits a programmed delay, then emits N pulses of programmed width separated by a programmed gap.
- Configured and monitored through the standard serial register interface (reg_cmd/reg_bytecount/reg_data_in/reg_data_out, command codes in commands.v).
- Its glitch_out drives the downstream glitch/trigger output.

Parameters:
- CNT_W, 24, width of the delay, width and gap registers and of the shared down-counter (3 register bytes).
- PULSES_W, 8, width of the pulse-count register.

Ports:
- timerclk  in  1  single clock; the register interface is also synchronous to it.
- reset  in  1  synchronous, active-high reset.
- trigger_in  in  1  external trigger; level input, rising edge detected internally.
- reg_cmd  in  8  register command.
- reg_bytecount  in  16  byte index within the register.
- reg_data_in  in  8  write data.
- reg_data_out  out  8  read data; combinational.
- reg_read  in  1  read strobe.
- reg_write  in  1  write strobe.
- glitch_out  out  1  sequenced pulse output; registered.
- busy  out  1  high in DELAY, PULSE and GAP.
- done  out  1  one-cycle pulse when a sequence completes.

Behaviour:
- Commands and byte ranges (byte 0 = LSB):
  - `SEQ_DELAY: 3 bytes, D.
  - `SEQ_WIDTH: 3 bytes, W.
  - `SEQ_GAP: 3 bytes, G.
  - `SEQ_COUNT: byte 0, N.
  - `SEQ_CTRL: bit0 arm, bit1 auto-rearm.
  - `SEQ_STATUS: read-only; bit0 busy, bit1 sticky done (cleared by next arm write), bits4:2 state encoding.
- Register access rules:
  - Writes with bytecount beyond the register size are ignored; such reads return 0.
  - Unknown cmd reads 0.
  - reg_data_out = 0 when reg_read is low.
- Reset: all registers, counter and edge-detect flop clear; state IDLE; glitch_out, busy, done = 0.
- Edge detect: trig_q registers trigger_in; edge = trigger_in & ~trig_q. A trigger held high produces exactly one edge.
- State IDLE: go to ARMED when arm=1.
- State ARMED: on edge, snapshot D/W/G/N into working copies and go to DELAY. Later register writes affect only the next shot.
- Timing, with the edge sampled at clock edge t:
  - glitch_out rises at t+D+1 (D=0 gives t+1).
  - Each pulse is high for max(W,1) cycles.
  - Between pulses glitch_out is low for max(G,1) cycles.
  - N=0 is treated as 1.
- State PULSE: after the last pulse, the next cycle is DONE.
- State DONE: lasts one cycle; done=1 and glitch_out=0.
  - Auto-rearm clear: arm clears and the state goes to IDLE.
  - Auto-rearm set: arm stays set and the state goes to ARMED.
- Edges arriving in DELAY, PULSE, GAP or DONE are ignored; no retrigger and no queueing.
- Abort: writing arm=0 in any non-IDLE state sends the state to IDLE next cycle. glitch_out drops that cycle, and done does not pulse.
- Writing arm=1 in the same cycle as an edge in IDLE: the edge is not captured, because ARMED is entered next cycle.
- Counter: one CNT_W down-counter, reloaded on each phase entry. No wrap: D = 2^24-1 counts fully.
- Reset mid-sequence: glitch_out=0 next cycle; all configuration is lost.

Optional Feature:
- Macro GLITCH_SEQ_AUTO_REARM_EN.
- Defined: SEQ_CTRL bit1 is implemented and the DONE→ARMED path exists.
- Undefined: bit1 is not stored and reads 0; every sequence is one-shot (DONE→IDLE, arm cleared).

Test Plan:
- D=5, W=3, N=1, arm, edge at cycle t → glitch_out high t+6..t+8; done at t+9; arm reads 0.
- D=0, W=0, G=0, N=3 → pulses high at t+1, t+3, t+5; done at t+6.
- N=2, D=10: hold trigger_in high 50 cycles, plus a second edge during GAP → exactly 2 pulses, a single sequence.
- D=100: write arm=0 at t+20 → glitch_out never asserts, no done, state IDLE, busy=0 from t+22.
- Reset asserted during PULSE → glitch_out=0 next cycle; all registers read 0.
- Macro defined, bit1=1, N=1: two edges 200 cycles apart → two pulses and two done pulses with no re-arm write. Macro undefined: second edge produces nothing.
